// File: rtl/key_entry_pkg.sv
// Shared codes, ASCII constants, state type and length-limit helper for key entry.
package key_entry_pkg;

    // Input styles, as sampled on start
    localparam logic [3:0] STYLE_SINGLE_KEY      = 4'd1;
    localparam logic [3:0] STYLE_ACC_NUMBER      = 4'd2;
    localparam logic [3:0] STYLE_PIN_NUMBER      = 4'd3;
    localparam logic [3:0] STYLE_MENU_SELECTION  = 4'd4;
    localparam logic [3:0] STYLE_CURRENCY_TYPE   = 4'd5;
    localparam logic [3:0] STYLE_CURRENCY_AMOUNT = 4'd6;

    // Status codes reported with status_valid
    localparam logic [3:0] STATUS_EXIT           = 4'd7;
    localparam logic [3:0] STATUS_INPUT_COMPLETE = 4'd8;

    localparam logic [7:0] ASCII_ENTER = 8'h0D;
    localparam logic [7:0] ASCII_BKSP  = 8'h08;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    typedef enum logic [1:0] {StIdle, StCollect, StDone, StAbort} entry_state_e;

    // Maximum number of digits a style may hold
    function automatic logic [3:0] max_len(input logic [3:0]  style,
                                           input int unsigned acc_len,
                                           input int unsigned pin_len,
                                           input int unsigned max_digits);
        case (style)
            STYLE_ACC_NUMBER:      max_len = 4'(acc_len);
            STYLE_PIN_NUMBER:      max_len = 4'(pin_len);
            STYLE_CURRENCY_AMOUNT: max_len = 4'(max_digits);
            default:               max_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Key-entry bus: requester (ATM FSM / keyboard path) is master, controller is slave.
interface key_entry_if #(
    parameter int unsigned MAX_DIGITS = 8
);
    logic                    start;
    logic [3:0]              input_style;
    logic                    key_valid;
    logic [7:0]              key_ascii;
    logic                    busy;
    logic [4*MAX_DIGITS-1:0] entry_value;
    logic [3:0]              digit_count;
    logic [MAX_DIGITS-1:0]   disp_mask;
    logic                    disp_hide;
    logic                    status_valid;
    logic [3:0]              status_code;
    logic                    entry_err;

    modport master (
        output start, input_style, key_valid, key_ascii,
        input  busy, entry_value, digit_count, disp_mask, disp_hide,
               status_valid, status_code, entry_err
    );

    modport slave (
        input  start, input_style, key_valid, key_ascii,
        output busy, entry_value, digit_count, disp_mask, disp_hide,
               status_valid, status_code, entry_err
    );
endinterface

// File: rtl/bcd_shift_buf.sv
// BCD digit buffer: push shifts a new digit into nibble 0, pop drops nibble 0.
module bcd_shift_buf #(
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [3:0]              digit_i,
    output logic [4*MAX_DIGITS-1:0] value_o,
    output logic [3:0]              count_o
);
    logic [4*MAX_DIGITS-1:0] value_q, value_d;
    logic [3:0]              count_q, count_d;

    // Next buffer contents; clear beats push beats pop, pop on empty is a no-op
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clear_i) begin
            value_d = '0;
            count_d = 4'd0;
        end else if (push_i) begin
            value_d = {value_q[4*MAX_DIGITS-5:0], digit_i};
            count_d = count_q + 4'd1;
        end else if (pop_i && (count_q != 4'd0)) begin
            value_d = value_q >> 4;
            count_d = count_q - 4'd1;
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            count_q <= 4'd0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value_o = value_q;
    assign count_o = count_q;
endmodule

// File: rtl/key_entry_ctrl.sv
// Multi-key numeric entry sequencer between the key decode path and the ATM FSM.
module key_entry_ctrl
    import key_entry_pkg::*;
#(
    parameter int unsigned MAX_DIGITS     = 8,
    parameter int unsigned ACC_LEN        = 6,
    parameter int unsigned PIN_LEN        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic         clk,
    input  logic         rst_n,
    key_entry_if.slave   kbd_io
);
    localparam int unsigned   CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    entry_state_e    state_q, state_d;
    logic [3:0]      style_q, style_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      code_q, code_d;
    logic            err_q, err_d;
    logic            buf_clear, buf_push, buf_pop;
    logic [3:0]      count;

    logic       style_legal, is_digit, digit_ok, auto_style, enter_ok;
    logic [3:0] limit;

    bcd_shift_buf #(
        .MAX_DIGITS(MAX_DIGITS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (buf_clear),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .digit_i (kbd_io.key_ascii[3:0]),
        .value_o (kbd_io.entry_value),
        .count_o (count)
    );

    // Key and style classification against the latched style
    always_comb begin
        style_legal = (kbd_io.input_style != 4'd0) &&
                      (kbd_io.input_style <= STYLE_CURRENCY_AMOUNT);
        is_digit    = (kbd_io.key_ascii >= ASCII_ZERO) && (kbd_io.key_ascii <= ASCII_NINE);
        limit       = max_len(style_q, ACC_LEN, PIN_LEN, MAX_DIGITS);
        auto_style  = (style_q == STYLE_SINGLE_KEY) || (style_q == STYLE_MENU_SELECTION) ||
                      (style_q == STYLE_CURRENCY_TYPE);
        case (style_q)
            STYLE_MENU_SELECTION: digit_ok = (kbd_io.key_ascii[3:0] >= 4'd1) &&
                                             (kbd_io.key_ascii[3:0] <= 4'd4);
            STYLE_CURRENCY_TYPE:  digit_ok = (kbd_io.key_ascii[3:0] >= 4'd1) &&
                                             (kbd_io.key_ascii[3:0] <= 4'd3);
            default:              digit_ok = 1'b1;
        endcase
        case (style_q)
            STYLE_ACC_NUMBER:      enter_ok = (count == 4'(ACC_LEN));
            STYLE_PIN_NUMBER:      enter_ok = (count == 4'(PIN_LEN));
            STYLE_CURRENCY_AMOUNT: enter_ok = (count != 4'd0);
            default:               enter_ok = 1'b0;
        endcase
    end

    // State register plus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            style_q <= 4'd0;
            cnt_q   <= '0;
            code_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            style_q <= style_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

    // Next state; start always wins over a key in the same cycle
    always_comb begin
        state_d   = state_q;
        style_d   = style_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        err_d     = 1'b0;
        buf_clear = 1'b0;
        buf_push  = 1'b0;
        buf_pop   = 1'b0;
        if (kbd_io.start) begin
            if (style_legal) begin
                style_d   = kbd_io.input_style;
                buf_clear = 1'b1;
                cnt_d     = '0;
                state_d   = StCollect;
            end else begin
                err_d = 1'b1;
                if (state_q != StCollect) state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (kbd_io.key_valid) begin
                        cnt_d = '0;
                        if (is_digit) begin
                            if ((count < limit) && digit_ok) begin
                                buf_push = 1'b1;
                                if (auto_style) begin
                                    state_d = StDone;
                                    code_d  = STATUS_INPUT_COMPLETE;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (kbd_io.key_ascii == ASCII_ENTER) begin
                            if (enter_ok) begin
                                state_d = StDone;
                                code_d  = STATUS_INPUT_COMPLETE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (kbd_io.key_ascii == ASCII_BKSP) begin
                            buf_pop = 1'b1;
                        end else if (kbd_io.key_ascii == ASCII_ESC) begin
                            state_d   = StAbort;
                            code_d    = STATUS_EXIT;
                            buf_clear = 1'b1;
                        end
                    end else if (cnt_q == CntLast) begin
                        state_d   = StAbort;
                        code_d    = STATUS_EXIT;
                        buf_clear = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDone, StAbort: state_d = StIdle;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and registered datapath
    always_comb begin
        kbd_io.busy         = (state_q == StCollect);
        kbd_io.status_valid = (state_q == StDone) || (state_q == StAbort);
        kbd_io.status_code  = code_q;
        kbd_io.entry_err    = err_q;
        kbd_io.disp_hide    = (style_q == STYLE_PIN_NUMBER);
        kbd_io.digit_count  = count;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            kbd_io.disp_mask[i] = (count > 4'(i));
        end
    end
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Randomised and directed checks of key_entry_ctrl against a digit-list reference model.
module tb_key_entry_ctrl;
    localparam int unsigned MaxDigits     = 8;
    localparam int unsigned AccLen        = 6;
    localparam int unsigned PinLen        = 4;
    localparam int unsigned TimeoutCycles = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_entry_if #(.MAX_DIGITS(MaxDigits)) kbd_if ();

    key_entry_ctrl #(
        .MAX_DIGITS     (MaxDigits),
        .ACC_LEN        (AccLen),
        .PIN_LEN        (PinLen),
        .TIMEOUT_CYCLES (TimeoutCycles)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .kbd_io (kbd_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: digits kept newest-first as plain integers
    bit m_busy;
    int m_digits[$];
    int m_style;
    int m_idle;
    bit m_pulse;
    int m_code;
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lim(input int style);
        case (style)
            2:       return int'(AccLen);
            3:       return int'(PinLen);
            6:       return int'(MaxDigits);
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] exp_value();
        logic [31:0] v = 0;
        foreach (m_digits[i]) v = v + (32'(m_digits[i]) << (4 * i));
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_digits.delete(); m_style = 0; m_idle = 0;
        m_pulse = 0; m_code = 0; m_err = 0;
    endtask

    task automatic model_finish(input int code);
        m_busy  = 0;
        m_pulse = 1;
        m_code  = code;
        if (code == 7) m_digits.delete();
    endtask

    task automatic model_step(input bit st, input int sty, input bit kv, input int a);
        int  d;
        bit  ok;
        m_pulse = 0;
        m_err   = 0;
        if (st) begin
            if (sty >= 1 && sty <= 6) begin
                m_style = sty; m_digits.delete(); m_busy = 1; m_idle = 0;
            end else begin
                m_err = 1;
            end
        end else if (m_busy) begin
            if (kv) begin
                m_idle = 0;
                if (a >= 48 && a <= 57) begin
                    d  = a - 48;
                    ok = m_digits.size() < lim(m_style);
                    if (m_style == 4 && (d < 1 || d > 4)) ok = 0;
                    if (m_style == 5 && (d < 1 || d > 3)) ok = 0;
                    if (ok) begin
                        m_digits.push_front(d);
                        if (m_style == 1 || m_style == 4 || m_style == 5) model_finish(8);
                    end else begin
                        m_err = 1;
                    end
                end else if (a == 13) begin
                    ok = (m_style == 2 && m_digits.size() == AccLen) ||
                         (m_style == 3 && m_digits.size() == PinLen) ||
                         (m_style == 6 && m_digits.size() >= 1);
                    if (ok) model_finish(8);
                    else m_err = 1;
                end else if (a == 8) begin
                    if (m_digits.size() > 0) void'(m_digits.pop_front());
                end else if (a == 27) begin
                    model_finish(7);
                end
            end else if (m_idle == int'(TimeoutCycles) - 1) begin
                model_finish(7);
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic check_all();
        int n = m_digits.size();
        check_eq("busy", 32'(kbd_if.busy), 32'(m_busy));
        check_eq("entry_value", kbd_if.entry_value, exp_value());
        check_eq("digit_count", 32'(kbd_if.digit_count), 32'(n));
        check_eq("disp_mask", 32'(kbd_if.disp_mask), (32'd1 << n) - 32'd1);
        check_eq("disp_hide", 32'(kbd_if.disp_hide), 32'(m_style == 3));
        check_eq("status_valid", 32'(kbd_if.status_valid), 32'(m_pulse));
        check_eq("status_code", 32'(kbd_if.status_code), 32'(m_code));
        check_eq("entry_err", 32'(kbd_if.entry_err), 32'(m_err));
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge
    task automatic cycle(input bit st, input logic [3:0] sty, input bit kv, input logic [7:0] a);
        kbd_if.start       = st;
        kbd_if.input_style = sty;
        kbd_if.key_valid   = kv;
        kbd_if.key_ascii   = a;
        model_step(st, int'(sty), kv, int'(a));
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 8'h00);
    endtask

    task automatic arm(input logic [3:0] sty);
        cycle(1'b1, sty, 1'b0, 8'h00);
    endtask

    task automatic key(input logic [7:0] a);
        cycle(1'b0, 4'd0, 1'b1, a);
    endtask

    initial begin
        int          first;
        bit          st, kv;
        int          r;
        logic [3:0]  sty;
        logic [7:0]  a;

        kbd_if.start = 0; kbd_if.input_style = 0; kbd_if.key_valid = 0; kbd_if.key_ascii = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // PIN entry completes on Enter with masking
        arm(4'd3);
        key("1"); key("2"); key("3"); key("4"); key(8'h0D);
        check_eq("pin_status_valid", 32'(kbd_if.status_valid), 32'd1);
        check_eq("pin_status_code", 32'(kbd_if.status_code), 32'd8);
        check_eq("pin_value", 32'(kbd_if.entry_value[15:0]), 32'h1234);
        check_eq("pin_count", 32'(kbd_if.digit_count), 32'd4);
        check_eq("pin_hide", 32'(kbd_if.disp_hide), 32'd1);
        idle();

        // Account number: short Enter rejected, full length accepted
        arm(4'd2);
        key("1"); key("2"); key("3"); key("4"); key("5"); key(8'h0D);
        check_eq("acc_short_err", 32'(kbd_if.entry_err), 32'd1);
        check_eq("acc_short_busy", 32'(kbd_if.busy), 32'd1);
        key("7"); key(8'h0D);
        check_eq("acc_done", 32'(kbd_if.status_code), 32'd8);
        check_eq("acc_nib0", 32'(kbd_if.entry_value[3:0]), 32'd7);
        check_eq("acc_count", 32'(kbd_if.digit_count), 32'd6);
        idle();

        // Amount with backspace, then backspace on empty buffer
        arm(4'd6);
        key("9"); key("8"); key(8'h08); key("5"); key(8'h0D);
        check_eq("amt_value", 32'(kbd_if.entry_value[7:0]), 32'h95);
        check_eq("amt_count", 32'(kbd_if.digit_count), 32'd2);
        idle();
        arm(4'd6);
        key(8'h08);
        check_eq("bksp_empty_err", 32'(kbd_if.entry_err), 32'd0);
        key(8'h1B);
        idle();

        // Menu selection: out-of-range digit rejected, valid one auto-completes
        arm(4'd4);
        key("7");
        check_eq("menu_err", 32'(kbd_if.entry_err), 32'd1);
        key("3");
        check_eq("menu_done", 32'(kbd_if.status_valid), 32'd1);
        check_eq("menu_nib0", 32'(kbd_if.entry_value[3:0]), 32'd3);
        check_eq("menu_count", 32'(kbd_if.digit_count), 32'd1);
        idle();

        // Inactivity timeout after the last key strobe
        arm(4'd6);
        key("5");
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            idle();
            if (kbd_if.status_valid && first == 0) begin
                first = k;
                check_eq("to_code", 32'(kbd_if.status_code), 32'd7);
                check_eq("to_count", 32'(kbd_if.digit_count), 32'd0);
                check_eq("to_busy", 32'(kbd_if.busy), 32'd0);
            end
        end
        check_eq("to_latency", 32'(first), 32'(TimeoutCycles));

        // Start and key together: key dropped; bad style flagged
        cycle(1'b1, 4'd4, 1'b1, "2");
        check_eq("b2b_count", 32'(kbd_if.digit_count), 32'd0);
        check_eq("b2b_busy", 32'(kbd_if.busy), 32'd1);
        arm(4'd9);
        check_eq("bad_style_err", 32'(kbd_if.entry_err), 32'd1);

        // Reset mid-entry clears everything at once
        arm(4'd6);
        key("1"); key("2");
        kbd_if.start = 0; kbd_if.key_valid = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check_eq("rst_value", kbd_if.entry_value, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            st  = m_busy ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
            sty = 4'($urandom_range(1, 6));
            kv  = ($urandom_range(0, 2) == 0);
            r   = $urandom_range(0, 19);
            if (r <= 11)      a = 8'h30 + 8'($urandom_range(0, 9));
            else if (r <= 14) a = 8'h0D;
            else if (r <= 16) a = 8'h08;
            else if (r == 17) a = ($urandom_range(0, 3) == 0) ? 8'h1B : 8'h31;
            else              a = 8'h41 + 8'($urandom_range(0, 5));
            cycle(st, sty, kv, a);
            if ($urandom_range(0, 199) == 0) repeat (22) idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
Sequences multi-key numeric entry between the PS2/ASCII decode path and the ATM FSM. Arms on a start pulse with an input style, then accumulates decimal digits into a BCD shift buffer, handling backspace, enter, escape and an inactivity timeout. On completion or abort it emits a one-cycle status pulse. It also drives digit-valid and masking controls to the seven-segment display path.

Parameters:
MAX_DIGITS, 8, BCD buffer depth in digits (legal 6..8)
ACC_LEN, 6, exact digit count for an account number
PIN_LEN, 4, exact digit count for a PIN
TIMEOUT_CYCLES, 1000000000, idle clocks in COLLECT before abort (10 s at 100 MHz)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a new entry
input_style  in  4  sampled on start: 1 SINGLE_KEY, 2 ACC_NUMBER, 3 PIN_NUMBER, 4 MENU_SELECTION, 5 CURRENCY_TYPE, 6 CURRENCY_AMOUNT
key_valid  in  1  one-cycle strobe; a new decoded key is present
key_ascii  in  8  ASCII code of the key
busy  out  1  high in COLLECT
entry_value  out  4*MAX_DIGITS  BCD digits, newest digit in nibble 0
digit_count  out  4  number of valid digits
disp_mask  out  MAX_DIGITS  bit i high when digit i is valid
disp_hide  out  1  high while the latched style is PIN_NUMBER (display shows placeholders)
status_valid  out  1  one-cycle pulse
status_code  out  4  8 INPUT_COMPLETE, 7 EXIT; holds its last value between pulses
entry_err  out  1  one-cycle pulse on a rejected key or a bad style

Behaviour:
- Reset: state IDLE. All outputs 0; entry_value, digit_count and timeout counter cleared.
- States: IDLE, COLLECT, DONE, ABORT. DONE and ABORT each last exactly 1 cycle, then return to IDLE.
- IDLE with start:
  - Legal style (1..6): latch style, clear buffer and count, go to COLLECT next cycle.
  - Illegal style (0 or >6): pulse entry_err, stay in IDLE.
- start in COLLECT: restart. Buffer cleared, new style latched, timeout reset, no status pulse.
- start and key_valid in the same cycle: start wins; the key is dropped.
- Key classes:
  - Digit: 0x30..0x39.
  - Enter: 0x0D.
  - Backspace: 0x08.
  - Escape: 0x1B.
  - Any other code is ignored silently.
- Keys are only acted on in COLLECT; key_valid is ignored in other states.
- Digit accepted: entry_value <= {entry_value[4*MAX_DIGITS-5:0], ascii-0x30}; digit_count +1. Buffer is updated on the cycle after the strobe.
- Digit with the style's length limit already reached: rejected; entry_err pulses, buffer unchanged.
- Length limits:
  - SINGLE_KEY, MENU_SELECTION, CURRENCY_TYPE: 1 digit.
  - ACC_NUMBER: ACC_LEN. PIN_NUMBER: PIN_LEN.
  - CURRENCY_AMOUNT: MAX_DIGITS.
- Auto-complete: SINGLE_KEY, MENU_SELECTION and CURRENCY_TYPE go to DONE on their single accepted digit, with no Enter.
  - MENU_SELECTION accepts only '1'..'4'.
  - CURRENCY_TYPE accepts only '1'..'3'.
  - Any other digit for these two styles: entry_err pulse, stay in COLLECT.
- Enter goes to DONE only when:
  - ACC_NUMBER: digit_count == ACC_LEN.
  - PIN_NUMBER: digit_count == PIN_LEN.
  - CURRENCY_AMOUNT: digit_count >= 1.
  - Otherwise: entry_err pulse, stay in COLLECT.
- Backspace: logical right shift of entry_value by 4; digit_count -1. With count 0 it is a no-op with no error.
- Escape: go to ABORT.
- Timeout: counter clears on entry to COLLECT and on every key_valid. When it reaches TIMEOUT_CYCLES-1: go to ABORT.
- DONE cycle: status_valid=1, status_code=8. entry_value and digit_count are held until the next accepted start.
- ABORT cycle: status_valid=1, status_code=7; buffer and count cleared.
- disp_mask[i] = (i < digit_count); combinational from the count.
- disp_hide follows the latched style; it is cleared only by reset or a new start.
- rst_n asserted mid-entry: immediate clear, no status pulse.

Decomposition:
- Shared package key_entry_pkg holds:
  - input-style codes and status codes (4-bit);
  - ASCII constants (ENTER, BKSP, ESC, ZERO, NINE);
  - state enum;
  - a function max_len(style) returning the digit limit.
- One natural sub-module: bcd_shift_buf. Parameter MAX_DIGITS; inputs push/pop/clear/digit; outputs value and count.

Test Plan:
- PIN style (3): keys '1','2','3','4', then Enter -> one-cycle status_valid, status_code=8, entry_value[15:0]=16'h1234, digit_count=4, disp_hide=1.
- ACC style (2): 5 digits then Enter -> entry_err pulse, still busy. A 6th digit '7' then Enter -> DONE with nibble 0 = 7, count 6.
- CURRENCY_AMOUNT: '9','8', Backspace, '5', Enter -> entry_value low byte 8'h95, count 2. Backspace at count 0 gives no entry_err.
- MENU_SELECTION: '7' -> entry_err. Then '3' -> DONE with no Enter, nibble 0 = 3, count 1.
- TIMEOUT_CYCLES=20, CURRENCY_AMOUNT, one digit, then silence -> status_code=7 exactly 20 cycles after the last key strobe; buffer cleared, busy=0.
- Back-to-back: start (style 4) in the same cycle as key_valid '2' -> key dropped, count 0. A further start with style 9 -> entry_err. rst_n low mid-entry -> all outputs 0 with no status pulse.
